fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the rv32i pipeline, directly upstream of the instruction ROM (IM).
- Owns the program counter and drives the byte address into IM, whose read is combinational.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles redirects from branches and jumps, stalls from the decode stage, halt on ECALL, and fetch faults.

Parameters:
- PC_WIDTH, 16, width of the PC and of every address port.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- IMEM_WORDS, 64, number of ROM words; a fetch at or beyond this word index is a fault.
- HALT_INSTR, 32'h00000073, instruction encoding that stops fetch (ECALL).
- NOP_INSTR, 32'h00000013, bubble value written into id_instr (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_pc  out  PC_WIDTH  byte address to IM; always equals the internal pc register
- imem_instr  in  32  instruction returned by IM for imem_pc, same cycle
- stall  in  1  decode not ready; hold pc and IF/ID
- redirect  in  1  branch taken or jump, from EX
- redirect_target  in  PC_WIDTH  new fetch address
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  IF/ID instruction
- id_pc  out  PC_WIDTH  address of id_instr
- id_pc_plus4  out  PC_WIDTH  id_pc+4, wrapped modulo 2^PC_WIDTH
- halted  out  1  fetch stopped
- fault_cause  out  2  00 none, 01 misaligned redirect, 10 fetch out of range
- fetch_count  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset is asynchronous and active-low, and takes effect immediately. Reset values:
  - pc=RESET_VECTOR, state=BOOT
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0
  - halted=0, fault_cause=00, fetch_count=0
- Reset asserted mid-operation discards all in-flight state. No partial update is permitted.
- The FSM has three states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - No capture; id_valid stays 0.
  - Transitions to RUN unconditionally; inputs are ignored.
- RUN: each rising edge evaluates the rules below in priority order.
  1. redirect=1:
     - If redirect_target[1:0]!=0: fault_cause<=01, state<=HALT, id_valid<=0, pc unchanged.
     - Otherwise: pc<=redirect_target, id_valid<=0, id_instr<=NOP_INSTR (flush).
     - Redirect beats stall. No capture happens and fetch_count is unchanged.
  2. stall=1: pc and all IF/ID registers hold; fetch_count holds.
  3. (pc>>2) >= IMEM_WORDS: fault_cause<=10, state<=HALT, id_valid<=0.
  4. Normal fetch:
     - Capture: id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, fetch_count<=fetch_count+1.
     - If imem_instr==HALT_INSTR: pc holds and state<=HALT.
     - Otherwise: pc<=pc+4, wrapping from 16'hFFFC to 16'h0000.
- HALT:
  - halted=1 combinationally from the state.
  - pc is frozen; redirect is ignored.
  - If stall=1, IF/ID holds, so the ECALL remains visible to decode. Otherwise id_valid<=0 and id_instr<=NOP_INSTR.
  - Exited only by reset.
- Latency:
  - An instruction appears on id_* one edge after its address is on imem_pc.
  - The first valid id_instr appears at the second rising edge after rst_n deasserts.
- fetch_count wraps modulo 2^32.
- Outputs are registered, except imem_pc (which is the pc register itself) and halted (decoded from the state register).

Decomposition:
- Shared package rv32i_pkg holds:
  - FSM state enum: BOOT, RUN, HALT
  - Fault-cause constants: FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE
  - NOP_INSTR and HALT_INSTR encodings
  - PC_WIDTH default
- One sub-module is natural: if_id_reg. It is the IF/ID register with load, hold, and flush controls, and is reused by later pipeline registers.
- PC selection and the FSM stay in fetch_stage.

Test Plan:
1. Reset release with IM loaded with the BEQ/JAL program (ROM[0]=00300413, ROM[1]=00100493, ...) and stall=0, redirect=0 -> imem_pc sequence 0,4,8,12,... starting one cycle after BOOT; id_instr=00300413 with id_pc=0 at edge 2, then 00100493 with id_pc=4; fetch_count=2.
2. redirect=1 with target=16'h0014 during a normal fetch cycle -> next edge: imem_pc=0014, id_valid=0, id_instr=00000013; following edge: id_instr=01228863, id_pc=0014, id_pc_plus4=0018.
3. stall=1 for 3 cycles while id_pc=8 -> id_pc, id_instr and imem_pc constant and fetch_count unchanged; after release, the next capture is id_pc=0C. Also assert stall and redirect (target=0) together -> redirect wins: pc=0, id_valid=0.
4. ROM[2]=00000073 -> captured with id_valid=1 and id_pc=8, then halted=1 and imem_pc stays 8. With stall=0 the next edge gives id_valid=0. A later redirect to target=0 leaves halted=1 and pc=8.
5. redirect with target=16'h0006 -> fault_cause=01, halted=1, id_valid=0. Separately, run past word 63 (pc=0x100, nothing but non-halt instructions in ROM) -> fault_cause=10, halted=1.
6. Pulse rst_n low asynchronously mid-run (between clock edges, with pc=0x10) -> pc=0, id_valid=0 and fetch_count=0 immediately; BOOT then RUN resumes from 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline definitions: FSM states, fault codes, fixed encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int DEFAULT_PC_WIDTH = 16;

    // addi x0,x0,0 is the bubble; ecall stops fetch.
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush (bubble) and drop (invalidate) controls.
// Latency: one clock from cap_* to outputs.
// Backpressure: holds contents whenever no control is asserted (stall).
// Ports: clk/rst_n; load/flush/drop controls (load > flush > drop);
//        cap_instr/cap_pc/cap_pc_plus4 capture data; valid/instr/pc/pc_plus4 outputs.
module if_id_reg #(
    parameter int          PC_WIDTH  = rv32i_pkg::DEFAULT_PC_WIDTH,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                flush,
    input  logic                drop,
    input  logic [31:0]         cap_instr,
    input  logic [PC_WIDTH-1:0] cap_pc,
    input  logic [PC_WIDTH-1:0] cap_pc_plus4,
    output logic                valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= cap_instr;
            pc       <= cap_pc;
            pc_plus4 <= cap_pc_plus4;
        end else if (flush) begin
            // Bubble: the address fields keep their last values.
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (drop) begin
            // Invalidate only; the stale instruction stays for debug visibility.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rv32i instruction fetch: owns the PC, addresses the combinational IM, fills IF/ID.
// Latency: instruction on id_* one edge after its address is on imem_pc; first valid at edge 2 after reset.
// Backpressure: stall holds pc and IF/ID; redirect overrides stall; halt is sticky until reset.
// Ports: clk, rst_n; imem_pc/imem_instr to IM; stall, redirect, redirect_target in;
//        id_valid/id_instr/id_pc/id_pc_plus4 to decode; halted, fault_cause, fetch_count status.
module fetch_stage #(
    parameter int                  PC_WIDTH     = rv32i_pkg::DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  IMEM_WORDS   = 64,
    parameter logic [31:0]         HALT_INSTR   = rv32i_pkg::HALT_INSTR,
    parameter logic [31:0]         NOP_INSTR    = rv32i_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] imem_pc,
    input  logic [31:0]         imem_instr,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    output logic                halted,
    output logic [1:0]          fault_cause,
    output logic [31:0]         fetch_count
);
    import rv32i_pkg::*;

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic [1:0]          fault_next;
    logic [31:0]         count_next;
    logic                ifid_load, ifid_flush, ifid_drop;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                out_of_range;

    // Natural modulo-2^PC_WIDTH wrap (FFFC -> 0000).
    assign pc_plus4     = pc + PC_WIDTH'(4);
    assign out_of_range = 32'(pc[PC_WIDTH-1:2]) >= 32'(IMEM_WORDS);
    assign imem_pc      = pc;
    assign halted       = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            fault_cause <= FAULT_NONE;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fault_cause <= fault_next;
            fetch_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        fault_next = fault_cause;
        count_next = fetch_count;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_drop  = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect) begin
                    if (redirect_target[1:0] != 2'b00) begin
                        fault_next = FAULT_MISALIGN;
                        state_next = HALT;
                        ifid_drop  = 1'b1;
                    end else begin
                        pc_next    = redirect_target;
                        ifid_flush = 1'b1;
                    end
                end else if (stall) begin
                    // Everything holds.
                end else if (out_of_range) begin
                    fault_next = FAULT_RANGE;
                    state_next = HALT;
                    ifid_drop  = 1'b1;
                end else begin
                    ifid_load  = 1'b1;
                    count_next = fetch_count + 32'd1;
                    if (imem_instr == HALT_INSTR) begin
                        // pc stays on the ecall so the halt address is observable.
                        state_next = HALT;
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            HALT: begin
                // Keep the ecall visible while decode is stalled, then drain.
                if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    if_id_reg #(
        .PC_WIDTH  (PC_WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (ifid_load),
        .flush        (ifid_flush),
        .drop         (ifid_drop),
        .cap_instr    (imem_instr),
        .cap_pc       (pc),
        .cap_pc_plus4 (pc_plus4),
        .valid        (id_valid),
        .instr        (id_instr),
        .pc           (id_pc),
        .pc_plus4     (id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus4;
    logic        halted;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    logic [31:0] rom [64];
    int          vectors = 0;
    int          miscompares = 0;
    logic        chk_en = 1'b0;

    assign imem_instr = (imem_pc < 16'd256) ? rom[imem_pc[7:2]] : NOP;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_pc         (imem_pc),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .halted          (halted),
        .fault_cause     (fault_cause),
        .fetch_count     (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // mode: 0 = boot cycle, 1 = fetching, 2 = stopped
    typedef struct {
        int          mode;
        logic [15:0] pc;
        logic        v;
        logic [31:0] instr;
        logic [15:0] ipc;
        logic [15:0] ipc4;
        logic [1:0]  fc;
        logic [31:0] cnt;
    } model_t;

    model_t m;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        if (a < 16'd256) return rom[a[7:2]];
        return NOP;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.pc = 16'h0; r.v = 1'b0; r.instr = NOP;
        r.ipc = 16'h0; r.ipc4 = 16'h0; r.fc = 2'b00; r.cnt = 32'h0;
        return r;
    endfunction

    function automatic model_t step(input model_t s, input logic st, input logic rd,
                                    input logic [15:0] tgt);
        model_t n = s;
        logic [31:0] w;
        if (s.mode == 0) begin
            n.mode = 1;
        end else if (s.mode == 1) begin
            if (rd) begin
                if (tgt % 4 != 0) begin
                    n.fc = 2'b01; n.mode = 2; n.v = 1'b0;
                end else begin
                    n.pc = tgt; n.v = 1'b0; n.instr = NOP;
                end
            end else if (st) begin
                n = s;
            end else if (int'(s.pc) / 4 >= 64) begin
                n.fc = 2'b10; n.mode = 2; n.v = 1'b0;
            end else begin
                w = rom_word(s.pc);
                n.instr = w; n.ipc = s.pc; n.ipc4 = 16'((int'(s.pc) + 4) % 65536);
                n.v = 1'b1; n.cnt = s.cnt + 1;
                if (w == ECALL) n.mode = 2;
                else n.pc = 16'((int'(s.pc) + 4) % 65536);
            end
        end else begin
            if (!st) begin
                n.v = 1'b0; n.instr = NOP;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= step(m, stall, redirect, redirect_target);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_imem_pc",  32'(imem_pc),     32'(m.pc));
            check("m_id_valid", 32'(id_valid),    32'(m.v));
            check("m_id_instr", id_instr,         m.instr);
            check("m_id_pc",    32'(id_pc),       32'(m.ipc));
            check("m_id_pc4",   32'(id_pc_plus4), 32'(m.ipc4));
            check("m_halted",   32'(halted),      32'(m.mode == 2));
            check("m_fault",    32'(fault_cause), 32'(m.fc));
            check("m_count",    fetch_count,      m.cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_rom(input bit with_ecall);
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013 | (32'(i) << 7);
        rom[0] = 32'h0030_0413;
        rom[1] = 32'h0010_0493;
        rom[5] = 32'h0122_8863;
        if (with_ecall) rom[2] = ECALL;
    endtask

    task automatic apply_reset(input bit with_ecall);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0;
        load_rom(with_ecall);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0;
        load_rom(1'b0);
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_count", fetch_count, 32'h0);

        // 1: sequential fetch from reset
        apply_reset(1'b0);
        tick();
        check("s1_boot_valid", 32'(id_valid), 32'h0);
        check("s1_boot_pc", 32'(imem_pc), 32'h0);
        tick();
        check("s1_i0", id_instr, 32'h0030_0413);
        check("s1_i0_pc", 32'(id_pc), 32'h0);
        check("s1_pc4", 32'(imem_pc), 32'h4);
        tick();
        check("s1_i1", id_instr, 32'h0010_0493);
        check("s1_i1_pc", 32'(id_pc), 32'h4);
        check("s1_count", fetch_count, 32'd2);

        // 2: redirect to 0x14
        redirect = 1'b1; redirect_target = 16'h0014;
        tick();
        redirect = 1'b0;
        check("s2_pc", 32'(imem_pc), 32'h14);
        check("s2_flush_v", 32'(id_valid), 32'h0);
        check("s2_flush_i", id_instr, NOP);
        tick();
        check("s2_instr", id_instr, 32'h0122_8863);
        check("s2_id_pc", 32'(id_pc), 32'h14);
        check("s2_id_pc4", 32'(id_pc_plus4), 32'h18);

        // 3: stall while id_pc=8, then redirect beats stall
        redirect = 1'b1; redirect_target = 16'h0008;
        tick();
        redirect = 1'b0;
        tick();
        check("s3_id_pc8", 32'(id_pc), 32'h8);
        stall = 1'b1;
        tick(3);
        check("s3_hold_pc", 32'(id_pc), 32'h8);
        check("s3_hold_imem", 32'(imem_pc), 32'hC);
        check("s3_hold_cnt", fetch_count, 32'd4);
        stall = 1'b0;
        tick();
        check("s3_next", 32'(id_pc), 32'hC);
        stall = 1'b1; redirect = 1'b1; redirect_target = 16'h0000;
        tick();
        stall = 1'b0; redirect = 1'b0;
        check("s3_rd_pc", 32'(imem_pc), 32'h0);
        check("s3_rd_v", 32'(id_valid), 32'h0);

        // 4: ecall at word 2
        apply_reset(1'b1);
        tick(4);
        check("s4_ecall", id_instr, ECALL);
        check("s4_ecall_v", 32'(id_valid), 32'h1);
        check("s4_ecall_pc", 32'(id_pc), 32'h8);
        check("s4_halted", 32'(halted), 32'h1);
        check("s4_pc", 32'(imem_pc), 32'h8);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("s4_stall_keep", 32'(id_valid), 32'h1);
        tick();
        check("s4_drain", 32'(id_valid), 32'h0);
        redirect = 1'b1; redirect_target = 16'h0;
        tick();
        redirect = 1'b0;
        check("s4_rd_halt", 32'(halted), 32'h1);
        check("s4_rd_pc", 32'(imem_pc), 32'h8);

        // 5a: misaligned redirect
        apply_reset(1'b0);
        tick(2);
        redirect = 1'b1; redirect_target = 16'h0006;
        tick();
        redirect = 1'b0;
        check("s5_mis_fault", 32'(fault_cause), 32'h1);
        check("s5_mis_halt", 32'(halted), 32'h1);
        check("s5_mis_v", 32'(id_valid), 32'h0);
        check("s5_mis_pc", 32'(imem_pc), 32'h4);

        // 5b: run off the end of the ROM
        apply_reset(1'b0);
        tick();
        guard = 0;
        while (!halted && guard < 200) begin
            tick();
            guard++;
        end
        check("s5_range_timeout", 32'(guard < 200), 32'h1);
        check("s5_range_fault", 32'(fault_cause), 32'h2);
        check("s5_range_pc", 32'(imem_pc), 32'h100);
        check("s5_range_cnt", fetch_count, 32'd64);
        check("s5_range_v", 32'(id_valid), 32'h0);

        // 6: asynchronous reset mid-run
        apply_reset(1'b0);
        tick(5);
        check("s6_pre_pc", 32'(imem_pc), 32'h10);
        #1 rst_n = 1'b0;
        #1;
        check("s6_async_pc", 32'(imem_pc), 32'h0);
        check("s6_async_v", 32'(id_valid), 32'h0);
        check("s6_async_cnt", fetch_count, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("s6_boot_v", 32'(id_valid), 32'h0);
        tick();
        check("s6_first", id_instr, 32'h0030_0413);
        check("s6_first_pc", 32'(id_pc), 32'h0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
